// File: rtl/aes128_dec_round_ctrl.sv
// Iterative AES-128 decryption controller: owns the state register, walks the
// inverse rounds one per clock and fetches round keys by index.

package aes_dec_pkg;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0 naturally).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x3, x7, x15, x31, x63, x127;
    x3   = gf_mul(gf_mul(x, x), x);
    x7   = gf_mul(gf_mul(x3, x3), x);
    x15  = gf_mul(gf_mul(x7, x7), x);
    x31  = gf_mul(gf_mul(x15, x15), x);
    x63  = gf_mul(gf_mul(x31, x31), x);
    x127 = gf_mul(gf_mul(x63, x63), x);
    return gf_mul(x127, x127);
  endfunction

  // Inverse affine transform followed by field inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] t;
    t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

endpackage

module aes_inv_shift_rows (
  input  logic [127:0] i_state,
  output logic [127:0] o_state
);
  // Row r of column c takes the byte from column (c - r) mod 4.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign o_state[127-8*(4*c+r) -: 8] = i_state[127-8*(4*((c+4-r)%4)+r) -: 8];
    end
  end
endmodule

module aes_inv_sub_bytes (
  input  logic [127:0] i_state,
  output logic [127:0] o_state
);
  for (genvar b = 0; b < 16; b++) begin : g_byte
    assign o_state[127-8*b -: 8] = aes_dec_pkg::inv_sbox(i_state[127-8*b -: 8]);
  end
endmodule

module aes_inv_mix_columns (
  input  logic [127:0] i_state,
  output logic [127:0] o_state
);
  import aes_dec_pkg::gf_mul;

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = i_state[127-32*c -: 8];
    assign w_a1 = i_state[119-32*c -: 8];
    assign w_a2 = i_state[111-32*c -: 8];
    assign w_a3 = i_state[103-32*c -: 8];
    assign o_state[127-32*c -: 8] = gf_mul(w_a0, 8'h0e) ^ gf_mul(w_a1, 8'h0b)
                                  ^ gf_mul(w_a2, 8'h0d) ^ gf_mul(w_a3, 8'h09);
    assign o_state[119-32*c -: 8] = gf_mul(w_a0, 8'h09) ^ gf_mul(w_a1, 8'h0e)
                                  ^ gf_mul(w_a2, 8'h0b) ^ gf_mul(w_a3, 8'h0d);
    assign o_state[111-32*c -: 8] = gf_mul(w_a0, 8'h0d) ^ gf_mul(w_a1, 8'h09)
                                  ^ gf_mul(w_a2, 8'h0e) ^ gf_mul(w_a3, 8'h0b);
    assign o_state[103-32*c -: 8] = gf_mul(w_a0, 8'h0b) ^ gf_mul(w_a1, 8'h0d)
                                  ^ gf_mul(w_a2, 8'h09) ^ gf_mul(w_a3, 8'h0e);
  end
endmodule

// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; valid is never withdrawn by this block before that edge. The input side
// additionally requires rk_valid, since the first AddRoundKey happens on accept.
module aes128_dec_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  input  logic         rk_valid,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_next_state;
  logic [127:0] r_st;
  logic [3:0]   r_rnd;
  logic         w_st_load;
  logic [127:0] w_st_next;
  logic         w_rnd_load;
  logic [3:0]   w_rnd_next;

  logic [127:0] w_isr;
  logic [127:0] w_isb;
  logic [127:0] w_ark;
  logic [127:0] w_imc;

  aes_inv_shift_rows  u_isr (.i_state(r_st),  .o_state(w_isr));
  aes_inv_sub_bytes   u_isb (.i_state(w_isr), .o_state(w_isb));
  assign w_ark = w_isb ^ rk_data;
  aes_inv_mix_columns u_imc (.i_state(w_ark), .o_state(w_imc));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_st    <= '0;
      r_rnd   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_st_load)  r_st  <= w_st_next;
      if (w_rnd_load) r_rnd <= w_rnd_next;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_st_load    = 1'b0;
    w_st_next    = r_st;
    w_rnd_load   = 1'b0;
    w_rnd_next   = r_rnd;
    case (r_state)
      S_IDLE: begin
        if (in_valid && rk_valid) begin
          w_st_load    = 1'b1;
          w_st_next    = in_data ^ rk_data;
          w_rnd_load   = 1'b1;
          w_rnd_next   = 4'(NR - 1);
          w_next_state = S_ROUND;
        end
      end
      S_ROUND: begin
        // A missing key freezes both the state and the round counter.
        if (rk_valid) begin
          w_st_load = 1'b1;
          w_st_next = w_imc;
          if (r_rnd == 4'd1) begin
            w_next_state = S_FINAL;
          end else begin
            w_rnd_load = 1'b1;
            w_rnd_next = r_rnd - 4'd1;
          end
        end
      end
      S_FINAL: begin
        if (rk_valid) begin
          w_st_load    = 1'b1;
          w_st_next    = w_ark;
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs depend only on the registered state, never on rk_valid.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    rk_idx    = 4'd0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        rk_idx   = 4'(NR);
      end
      S_ROUND: begin
        busy   = 1'b1;
        rk_idx = r_rnd;
      end
      S_FINAL: begin
        busy   = 1'b1;
        rk_idx = 4'd0;
      end
      S_DONE: begin
        out_valid = 1'b1;
        rk_idx    = 4'd0;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign out_data  = r_st;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_aes128_dec_round_ctrl.sv
// Directed bench for aes128_dec_round_ctrl using FIPS-197 vectors and a bench-side
// round-key table indexed by rk_idx.

module tb_aes128_dec_round_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         rk_valid;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic [1:0]   dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  int key_sel = 0;

  logic [127:0] key_tab [0:1][0:10];

  typedef struct {
    int           key_sel;
    logic [127:0] ct;
    logic [127:0] pt;
    logic [3:0]   stall_idx;
    int           stall_n;
    int           final_stall;
    int           exp_lat;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  assign rk_data = (rk_idx <= 4'd10) ? key_tab[key_sel][rk_idx] : '0;

  aes128_dec_round_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .rk_valid  (rk_valid),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs from just after the accept edge until out_valid is seen, driving the
  // key stalls described by the arguments and tracking the expected key index.
  task automatic finish_block(input string tag, input logic [127:0] pt,
                              input logic [3:0] stall_idx, input int stall_n,
                              input int final_stall, input int exp_lat);
    int           k;
    int           s_left;
    int           f_left;
    logic [3:0]   exp_idx;
    logic         prev_rkv;
    logic [127:0] prev_st;
    bit           seen;
    k = -1; s_left = stall_n; f_left = final_stall;
    exp_idx = 4'd9; prev_rkv = 1'b1; prev_st = '0; seen = 0;
    while (k < 60 && !seen) begin
      @(negedge clk);
      k++;
      if (out_valid) begin
        seen = 1;
        check({tag, " latency"}, 128'(k), 128'(exp_lat));
        check({tag, " out_data"}, out_data, pt);
      end else begin
        check({tag, " rk_idx"}, 128'(rk_idx), 128'(exp_idx));
        if (!prev_rkv) check({tag, " st frozen"}, out_data, prev_st);
        if (exp_idx == stall_idx && s_left > 0) begin
          rk_valid = 1'b0; s_left--;
        end else if (exp_idx == 4'd0 && f_left > 0) begin
          rk_valid = 1'b0; f_left--;
        end else begin
          rk_valid = 1'b1;
        end
        prev_st  = out_data;
        prev_rkv = rk_valid;
        if (rk_valid && exp_idx != 4'd0) exp_idx = exp_idx - 4'd1;
      end
    end
    rk_valid = 1'b1;
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("FAIL %s timeout: got no out_valid expected out_valid within 60 cycles", tag);
    end
  endtask

  task automatic check_idle_after(input string tag);
    @(negedge clk);
    check({tag, " out_valid drop"}, 128'(out_valid), 128'(0));
    check({tag, " in_ready back"}, 128'(in_ready), 128'(1));
    check({tag, " busy idle"}, 128'(busy), 128'(0));
  endtask

  task automatic run_vector(input vec_t v, input string tag);
    @(negedge clk);
    in_valid = 1'b1; in_data = v.ct; key_sel = v.key_sel;
    rk_valid = 1'b1; out_ready = 1'b1;
    check({tag, " in_ready idle"}, 128'(in_ready), 128'(1));
    check({tag, " rk_idx idle"}, 128'(rk_idx), 128'(10));
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = {$urandom, $urandom, $urandom, $urandom};
    finish_block(tag, v.pt, v.stall_idx, v.stall_n, v.final_stall, v.exp_lat);
    check_idle_after(tag);
  endtask

  initial begin
    int k;
    bit got;
    logic [127:0] held;

    key_tab[0][0]  = 128'h000102030405060708090a0b0c0d0e0f;
    key_tab[0][1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    key_tab[0][2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    key_tab[0][3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    key_tab[0][4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    key_tab[0][5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    key_tab[0][6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    key_tab[0][7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    key_tab[0][8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    key_tab[0][9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    key_tab[0][10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    key_tab[1][0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    key_tab[1][1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    key_tab[1][2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    key_tab[1][3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    key_tab[1][4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    key_tab[1][5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    key_tab[1][6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    key_tab[1][7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    key_tab[1][8]  = 128'head27321b58dbad2312bf5607f8d292f;
    key_tab[1][9]  = 128'hac7766f319fadc2128d12941575c006e;
    key_tab[1][10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    vecs[0] = '{0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                   128'h00112233445566778899aabbccddeeff, 4'd0, 0, 0, 10};
    vecs[1] = '{1, 128'h3925841d02dc09fbdc118597196a0b32,
                   128'h3243f6a8885a308d313198a2e0370734, 4'd0, 0, 0, 10};
    vecs[2] = '{0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                   128'h00112233445566778899aabbccddeeff, 4'd5, 3, 1, 14};
    vecs[3] = '{1, 128'h3925841d02dc09fbdc118597196a0b32,
                   128'h3243f6a8885a308d313198a2e0370734, 4'd9, 2, 0, 12};

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; rk_valid = 1'b1; out_ready = 1'b1;
    #12;
    check("reset in_ready", 128'(in_ready), 128'(1));
    check("reset rk_idx", 128'(rk_idx), 128'(10));
    check("reset busy", 128'(busy), 128'(0));
    check("reset out_valid", 128'(out_valid), 128'(0));
    check("reset out_data", out_data, 128'h0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_vector(vecs[i], $sformatf("vec%0d", i));

    // Output backpressure: five edges with out_ready low, in_valid noise ignored
    @(negedge clk);
    in_valid = 1'b1; in_data = vecs[0].ct; key_sel = 0; rk_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1; in_valid = 1'b0;
    finish_block("bp", vecs[0].pt, 4'd0, 0, 0, 10);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      @(negedge clk);
      check("bp out_valid hold", 128'(out_valid), 128'(1));
      check("bp out_data hold", out_data, vecs[0].pt);
      check("bp in_ready low", 128'(in_ready), 128'(0));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    check_idle_after("bp");

    // Accept gating: pending block waits for the key schedule
    @(negedge clk);
    in_valid = 1'b1; in_data = vecs[1].ct; key_sel = 1; rk_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("gate busy", 128'(busy), 128'(0));
      check("gate in_ready", 128'(in_ready), 128'(1));
    end
    rk_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    finish_block("gate", vecs[1].pt, 4'd0, 0, 0, 10);
    check_idle_after("gate");

    // Reset mid-operation at rnd = 4, between clock edges
    @(negedge clk);
    in_valid = 1'b1; in_data = vecs[0].ct; key_sel = 0; rk_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    k = 0;
    while (k < 20 && rk_idx != 4'd4) begin @(negedge clk); k++; end
    check("rst reach rnd4", 128'(rk_idx), 128'(4));
    #2 rst_n = 1'b0;
    #1;
    check("rst busy", 128'(busy), 128'(0));
    check("rst out_valid", 128'(out_valid), 128'(0));
    check("rst out_data", out_data, 128'h0);
    check("rst rk_idx", 128'(rk_idx), 128'(10));
    @(negedge clk); rst_n = 1'b1;
    run_vector(vecs[1], "post_rst");

    // Back-to-back: in_valid held, second accept 12 edges after the first
    @(negedge clk);
    in_valid = 1'b1; in_data = vecs[0].ct; key_sel = 0; rk_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; in_data = vecs[1].ct;
    k = -1; got = 0;
    while (k < 40 && !got) begin
      @(negedge clk); k++;
      if (out_valid) begin
        got = 1;
        check("b2b first data", out_data, vecs[0].pt);
        check("b2b first latency", 128'(k), 128'(10));
        key_sel = 1;
      end
    end
    while (k < 40 && !in_ready) begin @(negedge clk); k++; end
    check("b2b accept gap", 128'(k + 1), 128'(12));
    held = out_data;
    @(posedge clk); #1; in_valid = 1'b0;
    finish_block("b2b second", vecs[1].pt, 4'd0, 0, 0, 10);
    check_idle_after("b2b");
    check("b2b first kept until accept", held, vecs[0].pt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
